bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) for the calculator display path.
- Takes the unsigned binary result from the arithmetic unit and produces packed BCD digits for the 7-segment digit driver.
- Built around a per-digit 4-bit add-3 correction cell (if the digit is ≥5, add 3; else pass through), replicated DIGITS times and applied once per iteration.

Parameters:
- WIDTH, 8, width of the binary input in bits (≥1).
- DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH−1; elaboration-time error otherwise.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a conversion; accepted only in IDLE or DONE.
- bin  input  WIDTH  unsigned binary value; sampled only on the accepting edge.
- busy  output  1  high while a conversion is in progress (SHIFT state).
- done  output  1  one-cycle pulse marking a completed conversion.
- bcd  output  4*DIGITS  packed BCD result, digit 0 (units) in bits [3:0]; held between conversions.

Behaviour:
- Interface decision: one clock, clk; synchronous active-high reset, rst.
- Reset values: state=IDLE, busy=0, done=0, bcd=0, internal shift/BCD working registers=0, counter=0.
- States:
  - IDLE: waits for start.
  - SHIFT: runs iterations.
  - DONE: one cycle, done=1.
- Accept rule: start=1 in IDLE or DONE at edge E:
  - load binary shift register ← bin, BCD working register ← 0, counter ← WIDTH;
  - go to SHIFT.
- Iteration, each SHIFT edge:
  - correct every working digit (add 3 if ≥5, 4-bit result);
  - shift {working BCD, binary} left 1 bit, binary MSB entering digit-0 LSB;
  - decrement counter.
- Completion: on the edge where counter goes 1→0, write the corrected+shifted value directly into bcd and go to DONE.
- Latency: start high in cycle 0 → busy high in cycles 1..WIDTH → done high in cycle WIDTH+1 only (WIDTH=8: done in cycle 9). bcd new value is visible from cycle WIDTH+1.
- bcd is not updated with intermediate values; it changes only at completion or reset.
- DONE → IDLE if start=0; DONE → SHIFT (new load) if start=1. Back-to-back conversions are therefore spaced WIDTH+1 cycles apart.
- start during SHIFT: ignored. No queueing, bin not sampled, busy/counter unaffected.
- rst asserted mid-conversion: abort immediately to the reset values. No done pulse; bcd returns to 0.
- rst and start high on the same edge: reset wins.
- Arithmetic: correction never overflows a digit (input ≤9 before correction given the loop invariant). No carry between digits except via the shift.
- done and busy are never both high.

Decomposition:
- Shared calculator package holds:
  - state encoding constants (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10);
  - helper function for the counter width, clog2(WIDTH+1).
- One sub-module is natural: bcd_add3_cell (4-bit in, 4-bit out, purely combinational correction), instantiated DIGITS times via generate.
- FSM, counter and shift registers stay in bin2bcd_seq.

Test Plan:
1. Reset then start=1 with bin=8'd0 in cycle 0 → busy cycles 1–8, done only in cycle 9, bcd=12'h000.
2. Sweep bin=8'd5, 8'd9, 8'd10, 8'd99, 8'd100, 8'd255 → bcd = 12'h005, 12'h009, 12'h010, 12'h099, 12'h100, 12'h255 respectively; exhaustive 0..255 against a reference model as a closing sweep.
3. start with bin=8'd200, then pulse start with bin=8'd7 in cycle 4 → second request ignored; done in cycle 9 with bcd=12'h200; no further done.
4. start with bin=8'd123, assert rst in cycle 5 → busy=0, bcd=0 from cycle 6; no done pulse ever for that request.
5. Back-to-back: bin=8'd42 in cycle 0, start held high with bin=8'd250 in cycle 9 (DONE) → done cycle 9 with 12'h042, busy cycles 10–17, done cycle 18 with 12'h250; bcd holds 12'h042 through cycles 10–17.
6. rst and start high on the same edge → state stays IDLE, busy=0, done=0 the next cycle.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the calculator display path: FSM state encoding
// and elaboration-time sizing helpers for the binary-to-BCD converter.
package bin2bcd_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Number of decimal digits needed for the largest WIDTH-bit value.
  function automatic int min_digits(input int width);
    longint unsigned v;
    int              n;
    if (width >= 64)
      v = 64'hFFFF_FFFF_FFFF_FFFF;
    else
      v = (64'd1 << width) - 64'd1;
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3_cell.sv
// Double-dabble correction for one BCD digit: digits of 5 or more get +3
// so the following left shift carries correctly into the next digit.
module bcd_add3_cell (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Result appears on bcd together with a one-cycle done pulse WIDTH+1 cycles after start.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = cnt_width(WIDTH);
  localparam int BW = 4 * DIGITS;

  if (WIDTH < 1) begin : g_bad_width
    $error("bin2bcd_seq: WIDTH must be at least 1");
  end
  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small to represent 2^WIDTH-1");
  end

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] bin_sr;
  logic [BW-1:0]    work;
  logic [BW-1:0]    corrected;
  logic [BW+WIDTH-1:0] shifted;
  logic [BW-1:0]    work_next;
  logic [WIDTH-1:0] bin_next;
  logic             accept;
  logic             last_iter;

  for (genvar d = 0; d < DIGITS; d++) begin : g_cell
    bcd_add3_cell u_cell (
      .din  (work[4*d +: 4]),
      .dout (corrected[4*d +: 4])
    );
  end

  // The top bit of the corrected BCD falls off; the loop invariant keeps it zero.
  assign shifted   = {corrected, bin_sr} << 1;
  assign work_next = shifted[BW+WIDTH-1:WIDTH];
  assign bin_next  = shifted[WIDTH-1:0];

  assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_iter = (state == ST_SHIFT) && (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      bin_sr <= '0;
      work   <= '0;
      bcd    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state  <= ST_SHIFT;
            cnt    <= CW'(WIDTH);
            bin_sr <= bin;
            work   <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          cnt    <= cnt - CW'(1);
          bin_sr <= bin_next;
          work   <= work_next;
          if (last_iter) begin
            state <= ST_DONE;
            bcd   <= work_next;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: directed vector table, multi-cycle corner sequences,
// and random plus exhaustive sweeps against a decimal-digit reference model.
module tb_bin2bcd_seq;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  int n_pass  = 0;
  int n_total = 0;

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b;
    logic [11:0] e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [11:0] ref_bcd(input int n);
    logic [11:0] r;
    int v;
    v = n;
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and waits (bounded) for done; reports latency and busy count.
  task automatic run_conv(input logic [7:0] b, output int lat, output int nb,
                          output logic [11:0] res);
    start = 1'b1;
    bin   = b;
    step();
    start = 1'b0;
    bin   = 8'($urandom);
    lat   = 1;
    nb    = 0;
    while (!done && lat < 40) begin
      if (busy) nb++;
      step();
      lat++;
    end
    res = bcd;
  endtask

  initial begin
    vec_t        tbl[6];
    int          lat, nb, done_cnt, first_done;
    logic [11:0] res;
    logic        busy_ok, hold_ok, nodone_ok;
    logic [7:0]  rv;

    tbl[0] = '{8'd5,   12'h005};
    tbl[1] = '{8'd9,   12'h009};
    tbl[2] = '{8'd10,  12'h010};
    tbl[3] = '{8'd99,  12'h099};
    tbl[4] = '{8'd100, 12'h100};
    tbl[5] = '{8'd255, 12'h255};

    rst = 1'b1; start = 1'b0; bin = 8'd0;
    step();
    step();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_bcd",  32'(bcd),  32'd0);
    rst = 1'b0;

    // Zero input: busy in cycles 1..8, done only in cycle 9.
    start = 1'b1; bin = 8'd0;
    step();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      check($sformatf("zero_busy_c%0d", c), 32'(busy), 32'((c <= 8) ? 1 : 0));
      check($sformatf("zero_done_c%0d", c), 32'(done), 32'((c == 9) ? 1 : 0));
      if (c == 9) check("zero_bcd", 32'(bcd), 32'h000);
      step();
    end

    foreach (tbl[i]) begin
      run_conv(tbl[i].b, lat, nb, res);
      check($sformatf("tbl_bcd_%0d", tbl[i].b), 32'(res), 32'(tbl[i].e));
      check($sformatf("tbl_lat_%0d", tbl[i].b), 32'(lat), 32'd9);
      check($sformatf("tbl_busy_%0d", tbl[i].b), 32'(nb), 32'd8);
    end
    step();

    // start during SHIFT is ignored.
    start = 1'b1; bin = 8'd200;
    step();
    done_cnt = 0; first_done = 0; res = '0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 4) begin start = 1'b1; bin = 8'd7; end
      else start = 1'b0;
      if (done) begin
        done_cnt++;
        if (first_done == 0) begin first_done = c; res = bcd; end
      end
      step();
    end
    check("ignore_done_count", 32'(done_cnt), 32'd1);
    check("ignore_done_cycle", 32'(first_done), 32'd9);
    check("ignore_bcd",        32'(res), 32'h200);
    check("ignore_bcd_held",   32'(bcd), 32'h200);

    // Reset mid-conversion aborts with no done pulse.
    start = 1'b1; bin = 8'd123;
    step();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd",  32'(bcd),  32'd0);
    done_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (done) done_cnt++;
      step();
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);

    // Back-to-back: start held in DONE reloads immediately.
    start = 1'b1; bin = 8'd42;
    step();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) step();
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_bcd1",  32'(bcd),  32'h042);
    start = 1'b1; bin = 8'd250;
    step();
    start = 1'b0;
    busy_ok = 1'b1; hold_ok = 1'b1; nodone_ok = 1'b1;
    for (int c = 10; c <= 17; c++) begin
      if (!busy) busy_ok = 1'b0;
      if (bcd !== 12'h042) hold_ok = 1'b0;
      if (done) nodone_ok = 1'b0;
      step();
    end
    check("b2b_busy_10_17",  32'(busy_ok), 32'd1);
    check("b2b_hold_10_17",  32'(hold_ok), 32'd1);
    check("b2b_nodone_10_17", 32'(nodone_ok), 32'd1);
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_bcd2",  32'(bcd),  32'h250);

    // Reset beats start on the same edge.
    rst = 1'b1; start = 1'b1; bin = 8'd77;
    step();
    check("rst_start_busy", 32'(busy), 32'd0);
    check("rst_start_done", 32'(done), 32'd0);
    check("rst_start_bcd",  32'(bcd),  32'd0);
    rst = 1'b0; start = 1'b0;
    step();
    check("rst_start_idle", 32'(busy), 32'd0);

    for (int k = 0; k < 40; k++) begin
      rv = 8'($urandom_range(0, 255));
      run_conv(rv, lat, nb, res);
      check($sformatf("rand_bcd_%0d", rv), 32'(res), 32'(ref_bcd(int'(rv))));
      check($sformatf("rand_lat_%0d", rv), 32'(lat), 32'd9);
    end

    for (int v = 0; v < 256; v++) begin
      run_conv(8'(v), lat, nb, res);
      check($sformatf("sweep_bcd_%0d", v), 32'(res), 32'(ref_bcd(v)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
